// File: rtl/add_rr_sched_pkg.sv
// Shared constants and helpers for the round-robin adder scheduler.
package add_rr_sched_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_W    = 32;
  localparam int unsigned DEF_CNTW = 16;

  // Accept-to-response latency in cycles (fixed, independent of load).
  localparam int unsigned ADD_LAT  = 2;

  // Tag = {valid, lane index}.
  function automatic int unsigned tag_w(input int unsigned nreq);
    return $clog2(nreq) + 1;
  endfunction

endpackage

// File: rtl/add_rr_sched_if.sv
// Requester and adder-side bus of the scheduler.
interface add_rr_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 32
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_data;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_r;
  logic [W-1:0]      add_s;

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, add_s,
    output req_ready, resp_valid, resp_data, add_a, add_b, add_r
  );

  // Requesters plus adder side.
  modport master (
    output req_valid, req_a, req_b, add_s,
    input  req_ready, resp_valid, resp_data, add_a, add_b, add_r
  );

endinterface

// File: rtl/add_rr_sched_rr_pick.sv
// Combinational round-robin picker: first requesting lane at or above ptr, mod NREQ.
module add_rr_sched_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant_c,
  output logic [PW-1:0]   o_idx_c,
  output logic            o_any_c
);

  // Scan lanes ptr, ptr+1, ... wrapping; the first valid one wins.
  always_comb begin
    int unsigned lane;
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    lane      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      lane = 32'(i_ptr) + k;
      if (lane >= NREQ) begin
        lane = lane - NREQ;
      end
      if (!o_any_c && i_req[PW'(lane)]) begin
        o_any_c              = 1'b1;
        o_idx_c              = PW'(lane);
        o_grant_c[PW'(lane)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_rr_sched.sv
// Round-robin scheduler time-sharing one adder among NREQ requesters.
// One accept per cycle; each sum returns to its issuer two cycles later.
module add_rr_sched
  import add_rr_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W    = DEF_W,
  parameter int unsigned CNTW = DEF_CNTW
) (
  input  logic                 clk,
  input  logic                 rst,
  add_rr_sched_if.slave        sched_bus,
  output logic [CNTW-1:0]      op_count
);

  localparam int unsigned PW   = $clog2(NREQ);
  localparam int unsigned TAGW = tag_w(NREQ);

  logic [PW-1:0]   r_ptr;
  logic [W-1:0]    r_add_a;
  logic [W-1:0]    r_add_b;
  logic            r_add_r;
  logic [TAGW-1:0] r_tag0;
  logic [TAGW-1:0] r_tag1;
  logic [W-1:0]    r_resp_data;
  logic [CNTW-1:0] r_op_count;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [W-1:0]    w_op_a;
  logic [W-1:0]    w_op_b;
  logic [PW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_resp_valid;

  add_rr_sched_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req     (sched_bus.req_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_any_c   (w_any)
  );

  // Grant is combinational; suppressed while in reset.
  assign sched_bus.req_ready = rst ? '0 : w_grant;

  // One-hot operand mux for the granted lane.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_op_a = sched_bus.req_a[i*W +: W];
        w_op_b = sched_bus.req_b[i*W +: W];
      end
    end
  end

  // Pointer moves to the lane after the one just granted.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_any) begin
      w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
    end
  end

  // Issue stage: operand registers, adder load, pointer, op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_add_r    <= 1'b0;
      r_ptr      <= '0;
      r_op_count <= '0;
    end else begin
      r_add_r <= w_any;
      r_ptr   <= w_ptr_nxt;
      if (w_any) begin
        r_add_a    <= w_op_a;
        r_add_b    <= w_op_b;
        r_op_count <= r_op_count + CNTW'(1);
      end
    end
  end

  // Tag pipe follows each op through the adder so the sum finds its issuer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag0 <= '0;
      r_tag1 <= '0;
    end else begin
      r_tag0 <= {w_any, w_idx};
      r_tag1 <= r_tag0;
    end
  end

  // Capture the adder sum while its tag is in the adder stage; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_data <= '0;
    end else if (r_tag0[TAGW-1]) begin
      r_resp_data <= sched_bus.add_s;
    end
  end

  // Response strobe decoded from the registered second tag stage.
  always_comb begin
    w_resp_valid = '0;
    if (r_tag1[TAGW-1]) begin
      w_resp_valid[r_tag1[PW-1:0]] = 1'b1;
    end
  end

  assign sched_bus.resp_valid = w_resp_valid;
  assign sched_bus.resp_data  = r_resp_data;
  assign sched_bus.add_a      = r_add_a;
  assign sched_bus.add_b      = r_add_b;
  assign sched_bus.add_r      = r_add_r;
  assign op_count             = r_op_count;

endmodule

// File: tb/tb_add_rr_sched.sv
// Bench for add_rr_sched: per-cycle reference model plus directed literal checks.
module tb_add_rr_sched;
  import add_rr_sched_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned CNTW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNTW-1:0] op_count;

  always #5 clk = ~clk;

  add_rr_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  add_rr_sched #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sched_bus (bus),
    .op_count  (op_count)
  );

  // Adder: operands arrive registered, so the sum is valid within the load cycle.
  assign bus.add_s = bus.add_a + bus.add_b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned      lane;
    logic [W-1:0]     sum;
    longint unsigned  due;
  } pend_t;

  pend_t            pq[$];
  bit               m_known = 1'b0;
  int unsigned      m_ptr = 0;
  logic [W-1:0]     m_add_a = '0;
  logic [W-1:0]     m_add_b = '0;
  logic             m_add_r = 1'b0;
  logic [CNTW-1:0]  m_cnt = '0;
  logic [NREQ-1:0]  m_rv = '0;
  logic [W-1:0]     m_rd = '0;
  longint unsigned  cyc = 0;

  // Compare outputs against the model each cycle, then advance the model.
  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    int              best;
    int unsigned     bestd;
    int unsigned     d;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [W-1:0]    s;
    pend_t           p;
    cyc++;
    eg    = '0;
    best  = -1;
    bestd = NREQ;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i]) begin
          d = (i + NREQ - m_ptr) % NREQ;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
    end
    if (best >= 0) eg[best] = 1'b1;

    if (m_known) begin
      chk("req_ready",  bus.req_ready,  eg);
      chk("add_r",      bus.add_r,      m_add_r);
      chk("add_a",      bus.add_a,      m_add_a);
      chk("add_b",      bus.add_b,      m_add_b);
      chk("resp_valid", bus.resp_valid, m_rv);
      chk("resp_data",  bus.resp_data,  m_rd);
      chk("op_count",   op_count,       m_cnt);
    end

    if (rst) begin
      m_known = 1'b1;
      m_ptr   = 0;
      m_add_a = '0;
      m_add_b = '0;
      m_add_r = 1'b0;
      m_cnt   = '0;
      m_rv    = '0;
      m_rd    = '0;
      pq.delete();
    end else begin
      m_add_r = (best >= 0);
      if (pq.size() > 0 && pq[0].due == cyc + 1) begin
        m_rv = '0;
        m_rv[pq[0].lane] = 1'b1;
        m_rd = pq[0].sum;
        void'(pq.pop_front());
      end else begin
        m_rv = '0;
      end
      if (best >= 0) begin
        a       = bus.req_a[best*W +: W];
        b       = bus.req_b[best*W +: W];
        s       = a + b;
        m_add_a = a;
        m_add_b = b;
        m_ptr   = (best + 1) % NREQ;
        m_cnt   = m_cnt + CNTW'(1);
        p.lane  = best;
        p.sum   = s;
        p.due   = cyc + ADD_LAT;
        pq.push_back(p);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0]    qa[NREQ][$];
  logic [W-1:0]    qb[NREQ][$];
  logic [NREQ-1:0] stream = '0;
  logic [W-1:0]    scnt[NREQ];

  logic [NREQ-1:0] s_rdy;
  logic [NREQ-1:0] s_rv;
  logic [W-1:0]    s_rd;
  logic            s_add_r;
  logic [W-1:0]    s_add_a;
  logic [CNTW-1:0] s_cnt;

  task automatic push(input int lane, input logic [W-1:0] a, input logic [W-1:0] b);
    qa[lane].push_back(a);
    qb[lane].push_back(b);
  endtask

  // One cycle: present operands, sample outputs mid-cycle, retire accepted ops.
  task automatic step();
    for (int i = 0; i < NREQ; i++) begin
      if (stream[i]) begin
        bus.req_valid[i]      = 1'b1;
        bus.req_a[i*W +: W]   = scnt[i];
        bus.req_b[i*W +: W]   = scnt[i] * 32'd3 + W'(i);
      end else if (qa[i].size() > 0) begin
        bus.req_valid[i]      = 1'b1;
        bus.req_a[i*W +: W]   = qa[i][0];
        bus.req_b[i*W +: W]   = qb[i][0];
      end else begin
        bus.req_valid[i]      = 1'b0;
      end
    end
    @(negedge clk);
    s_rdy   = bus.req_ready;
    s_rv    = bus.resp_valid;
    s_rd    = bus.resp_data;
    s_add_r = bus.add_r;
    s_add_a = bus.add_a;
    s_cnt   = op_count;
    @(posedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (s_rdy[i]) begin
        if (stream[i]) begin
          scnt[i] = scnt[i] + 32'd1;
        end else if (qa[i].size() > 0) begin
          void'(qa[i].pop_front());
          void'(qb[i].pop_front());
        end
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    stream = '0;
    for (int i = 0; i < NREQ; i++) begin
      qa[i].delete();
      qb[i].delete();
    end
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < NREQ; i++) scnt[i] = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Reset state.
    step();
    chk("rst_ready",      s_rdy,   4'b0000);
    chk("rst_add_r",      s_add_r, 1'b0);
    chk("rst_resp_valid", s_rv,    4'b0000);
    chk("rst_resp_data",  s_rd,    32'd0);
    chk("rst_op_count",   s_cnt,   16'd0);

    // 1. Single lane: 5 + 7.
    do_reset(1);
    push(0, 32'd5, 32'd7);
    step();
    chk("t1_ready", s_rdy, 4'b0001);
    step();
    chk("t1_add_r", s_add_r, 1'b1);
    chk("t1_add_a", s_add_a, 32'd5);
    step();
    chk("t1_resp_valid", s_rv, 4'b0001);
    chk("t1_resp_data",  s_rd, 32'd12);

    // 2. All lanes valid: grants rotate, responses follow two cycles later.
    do_reset(1);
    for (int k = 0; k < 8; k++) push(k % 4, 32'(100 + k), 32'(k));
    for (int k = 0; k < 10; k++) begin
      step();
      if (k < 8) chk("t2_grant", s_rdy, 64'(1) << (k % 4));
      if (k >= 2) begin
        chk("t2_resp_valid", s_rv, 64'(1) << ((k - 2) % 4));
        chk("t2_resp_data",  s_rd, 64'(100 + 2 * (k - 2)));
      end
      if (k == 8) chk("t2_op_count", s_cnt, 16'd8);
    end

    // 3. Sum wraps mod 2^W.
    do_reset(1);
    push(2, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("t3_ready", s_rdy, 4'b0100);
    step();
    step();
    chk("t3_resp_valid", s_rv, 4'b0100);
    chk("t3_resp_data",  s_rd, 32'd0);

    // 3b. op_count wraps after 2^16 accepts.
    do_reset(1);
    stream = 4'b0001;
    repeat (65536) step();
    chk("t3_op_count_top", s_cnt, 16'hFFFF);
    stream = '0;
    step();
    chk("t3_op_count_wrap", s_cnt, 16'd0);
    repeat (3) step();

    // 4. Sparse lanes 1 and 3 with ptr at 2.
    do_reset(1);
    push(1, 32'd10, 32'd20);
    step();
    chk("t4_first", s_rdy, 4'b0010);
    step();
    push(1, 32'd30, 32'd40);
    push(3, 32'd50, 32'd60);
    step();
    chk("t4_lane3_first", s_rdy,   4'b1000);
    chk("t4_idle_add_r",  s_add_r, 1'b0);
    chk("t4_hold_a",      s_add_a, 32'd10);
    step();
    chk("t4_lane1_next",  s_rdy,   4'b0010);
    chk("t4_add_a",       s_add_a, 32'd50);
    step();
    chk("t4_resp3",       s_rv,    4'b1000);
    chk("t4_resp3_data",  s_rd,    32'd110);
    step();
    chk("t4_idle2_add_r", s_add_r, 1'b0);
    chk("t4_hold2_a",     s_add_a, 32'd30);
    chk("t4_resp1",       s_rv,    4'b0010);
    chk("t4_resp1_data",  s_rd,    32'd70);

    // 5. Reset with two ops in flight.
    do_reset(1);
    push(0, 32'd1, 32'd2);
    push(1, 32'd3, 32'd4);
    step();
    step();
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_no_resp",  s_rv,    4'b0000);
      chk("t5_add_r",    s_add_r, 1'b0);
      chk("t5_resp_data", s_rd,   32'd0);
      chk("t5_op_count", s_cnt,   16'd0);
    end
    push(2, 32'd8, 32'd8);
    push(0, 32'd7, 32'd7);
    step();
    chk("t5_lane0_first", s_rdy, 4'b0001);
    step();
    chk("t5_lane2_next",  s_rdy, 4'b0100);
    repeat (3) step();

    // 6. Lane 0 re-requests back to back.
    do_reset(1);
    push(0, 32'd1, 32'd1);
    push(0, 32'd2, 32'd2);
    push(0, 32'd3, 32'd3);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 3) chk("t6_grant", s_rdy, 4'b0001);
      if (k >= 2) begin
        chk("t6_resp_valid", s_rv, 4'b0001);
        chk("t6_resp_data",  s_rd, 64'(2 * (k - 1)));
      end
    end
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
